// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes,
// fetch FSM state encoding and reset defaults.
package fetch_unit_pkg;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_PCIMM  = 2'b01;
    localparam logic [1:0] PC_SEL_RS1IMM = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        StReset,
        StReq,
        StWait,
        StHold,
        StFault
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection from decode controls, plus a flag for a
// target that is not word aligned.
module fetch_unit_next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic        branch_taken,
    input  logic [31:0] imm_32,
    input  logic [31:0] rs1_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] pc_plus_4;
    logic [31:0] pc_plus_imm;
    logic [31:0] rs1_plus_imm;

    always_comb begin
        pc_plus_4    = pc + 32'd4;
        pc_plus_imm  = pc + imm_32;
        rs1_plus_imm = rs1_data + imm_32;

        next_pc = pc_plus_4;
        unique case (pc_sel)
            PC_SEL_SEQ:    next_pc = branch_taken ? pc_plus_imm : pc_plus_4;
            PC_SEL_PCIMM:  next_pc = pc_plus_imm;
            // Indirect jump target drops bit 0; bit 1 still flags a misaligned target.
            PC_SEL_RS1IMM: next_pc = {rs1_plus_imm[31:1], 1'b0};
            default:       next_pc = pc_plus_4;
        endcase

        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time and
// holds the fetched word until retire, then steers to the next PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    input  logic        retire,
    input  logic [1:0]  pc_sel,
    input  logic        branch_taken,
    input  logic [31:0] imm_32,
    input  logic [31:0] rs1_data,
    output logic        fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         fault_q, fault_d;

    logic [31:0]  next_pc;
    logic         next_pc_misaligned;

    fetch_unit_next_pc_calc u_next_pc_calc (
        .pc           (pc_q),
        .pc_sel       (pc_sel),
        .branch_taken (branch_taken),
        .imm_32       (imm_32),
        .rs1_data     (rs1_data),
        .next_pc      (next_pc),
        .misaligned   (next_pc_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StReset;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;

        unique case (state_q)
            StReset: begin
                state_d = StReq;
            end
            StReq: begin
                if (imem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // Responses are only meaningful here; stray ones elsewhere are dropped.
                if (imem_resp_valid) begin
                    instr_d       = imem_resp_data;
                    instr_valid_d = 1'b1;
                    state_d       = StHold;
                end
            end
            StHold: begin
                if (retire) begin
                    pc_d          = next_pc;
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b0;
                    if (next_pc_misaligned) begin
                        fault_d = 1'b1;
                        state_d = StFault;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StReset;
            end
        endcase
    end

    assign imem_req_valid = (state_q == StReq);
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instruction    = instr_q;
    assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays both memory and decode,
// driving on the falling edge and sampling just before each drive.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        retire;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic [31:0] imm_32;
    logic [31:0] rs1_data;
    logic        fetch_fault;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instruction     (instruction),
        .pc              (pc),
        .retire          (retire),
        .pc_sel          (pc_sel),
        .branch_taken    (branch_taken),
        .imm_32          (imm_32),
        .rs1_data        (rs1_data),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    endtask

    // Bounded wait for a request; an expired bound shows up as a failed check.
    task automatic wait_req(input string tag);
        int i = 0;
        while (imem_req_valid !== 1'b1 && i < 8) begin
            @(negedge clk);
            i++;
        end
        check_eq({tag, " req_valid"}, 32'(imem_req_valid), 32'd1);
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        wait_req(tag);
        check_eq({tag, " addr"}, imem_addr, addr);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check_eq({tag, " wait no req"}, 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'hDEAD_BEEF;
        check_eq({tag, " instr_valid"}, 32'(instr_valid), 32'd1);
        check_eq({tag, " instruction"}, instruction, data);
        check_eq({tag, " pc"}, pc, addr);
    endtask

    task automatic do_retire(input logic [1:0] sel, input logic br, input logic [31:0] imm,
                             input logic [31:0] rs1);
        pc_sel       = sel;
        branch_taken = br;
        imm_32       = imm;
        rs1_data     = rs1;
        retire       = 1'b1;
        @(negedge clk);
        retire       = 1'b0;
        pc_sel       = 2'b00;
        branch_taken = 1'b0;
        imm_32       = 32'h0;
        rs1_data     = 32'h0;
    endtask

    // Retire and expect a legal target: new pc and request visible one cycle later.
    task automatic retire_to(input string tag, input logic [1:0] sel, input logic br,
                             input logic [31:0] imm, input logic [31:0] rs1,
                             input logic [31:0] exp_pc);
        do_retire(sel, br, imm, rs1);
        check_eq({tag, " pc"}, pc, exp_pc);
        check_eq({tag, " req_valid"}, 32'(imem_req_valid), 32'd1);
        check_eq({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
        check_eq({tag, " nop"}, instruction, NOP);
        check_eq({tag, " no fault"}, 32'(fetch_fault), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        retire          = 1'b0;
        pc_sel          = 2'b00;
        branch_taken    = 1'b0;
        imm_32          = 32'h0;
        rs1_data        = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst instruction", instruction, NOP);
        check_eq("rst fault", 32'(fetch_fault), 32'd0);
        check_eq("rst pc", pc, 32'h0);
        rst = 1'b0;
        #1;
        check_eq("gap req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        check_eq("first req", 32'(imem_req_valid), 32'd1);
        fetch("boot", 32'h0, 32'h0050_0093);

        // Stray response while holding must not disturb the held word.
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0BAD_0BAD;
        @(negedge clk);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        check_eq("stray hold instr", instruction, 32'h0050_0093);
        check_eq("stray hold valid", 32'(instr_valid), 32'd1);
        check_eq("stray hold pc", pc, 32'h0);

        retire_to("jump10", PC_SEL_PCIMM, 1'b0, 32'h10, 32'h0, 32'h10);
        fetch("f10", 32'h10, 32'h0000_0033);
        retire_to("seq", PC_SEL_SEQ, 1'b0, 32'h40, 32'h0, 32'h14);

        // Stall: ready low, plus retire and response pulses that must be ignored.
        for (int i = 0; i < 3; i++) begin
            retire          = 1'b1;
            pc_sel          = PC_SEL_PCIMM;
            imm_32          = 32'h100;
            imem_resp_valid = 1'b1;
            @(negedge clk);
            check_eq("stall req_valid", 32'(imem_req_valid), 32'd1);
            check_eq("stall addr", imem_addr, 32'h14);
            check_eq("stall instr_valid", 32'(instr_valid), 32'd0);
        end
        retire          = 1'b0;
        pc_sel          = 2'b00;
        imm_32          = 32'h0;
        imem_resp_valid = 1'b0;
        fetch("f14", 32'h14, 32'h0010_0113);

        retire_to("to100", PC_SEL_RS1IMM, 1'b0, 32'h0, 32'h100, 32'h100);
        fetch("f100a", 32'h100, 32'h1111_1113);
        retire_to("beq", PC_SEL_SEQ, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'hF0);
        fetch("ff0", 32'hF0, 32'h2222_2213);
        retire_to("back100", PC_SEL_RS1IMM, 1'b0, 32'h0, 32'h100, 32'h100);
        fetch("f100b", 32'h100, 32'h3333_3313);
        retire_to("jal", PC_SEL_PCIMM, 1'b0, 32'h20, 32'h0, 32'h120);
        fetch("f120", 32'h120, 32'h4444_4413);
        retire_to("sel11", 2'b11, 1'b1, 32'h80, 32'h0, 32'h124);
        fetch("f124", 32'h124, 32'h5555_5513);
        retire_to("jalr", PC_SEL_RS1IMM, 1'b0, 32'h4, 32'h2001, 32'h2004);

        // Reset while the read is in flight; the stale response must be dropped.
        wait_req("midwait");
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check_eq("midwait in wait", 32'(imem_req_valid), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("midrst pc", pc, 32'h0);
        check_eq("midrst instr_valid", 32'(instr_valid), 32'd0);
        check_eq("midrst req_valid", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0BAD_BAD3;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("stale resp ignored", 32'(instr_valid), 32'd0);
        imem_resp_valid = 1'b0;
        fetch("postrst", 32'h0, 32'h0020_0193);

        retire_to("prewrap", PC_SEL_RS1IMM, 1'b0, 32'h4, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
        fetch("ffffc", 32'hFFFF_FFFC, 32'h6666_6613);
        retire_to("wrap", PC_SEL_SEQ, 1'b0, 32'h0, 32'h0, 32'h0);
        fetch("fwrap", 32'h0, 32'h7777_7713);

        // Misaligned jalr target: sticky fault, no further requests.
        do_retire(PC_SEL_RS1IMM, 1'b0, 32'h4, 32'h2002);
        check_eq("fault flag", 32'(fetch_fault), 32'd1);
        check_eq("fault pc", pc, 32'h2006);
        check_eq("fault instr_valid", 32'(instr_valid), 32'd0);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            retire = 1'b1;
            @(negedge clk);
            check_eq("fault no req", 32'(imem_req_valid), 32'd0);
            check_eq("fault sticky", 32'(fetch_fault), 32'd1);
        end
        retire         = 1'b0;
        imem_req_ready = 1'b0;

        rst = 1'b1;
        #1;
        check_eq("clear fault", 32'(fetch_fault), 32'd0);
        check_eq("clear pc", pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
